// File: rtl/seg7_scan_driver_pkg.sv
// seg7_scan_driver_pkg: shared constants, scan-state enum and hex segment table
package seg7_scan_driver_pkg;

  localparam int NUM_DIGITS = 4;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  // Active-high gfedcba patterns, entry 15 first so HEX_SEG[n] is digit n
  localparam logic [15:0][6:0] HEX_SEG = {
    7'b1110001,  // F
    7'b1111001,  // E
    7'b1011110,  // d
    7'b0111001,  // C
    7'b1111100,  // b
    7'b1110111,  // A
    7'b1101111,  // 9
    7'b1111111,  // 8
    7'b0000111,  // 7
    7'b1111101,  // 6
    7'b1101101,  // 5
    7'b1100110,  // 4
    7'b1001111,  // 3
    7'b1011011,  // 2
    7'b0000110,  // 1
    7'b0111111   // 0
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: nibble to active-high 7-segment pattern (bit0 = a .. bit6 = g)
module seg7_hex_decode
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 4-digit multiplexed 7-segment scanner with blanking and frame-latched value
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int SCAN_DIV    = 256,
  parameter int DRIVE_TICKS = 3,
  parameter int BLANK_TICKS = 1,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                      sys_clock,
  input  logic                      sys_reset,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   value_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     en_in,
  output logic [6:0]                seg_out,
  output logic                      dp_out,
  output logic [NUM_DIGITS-1:0]     digit_out,
  output logic                      frame_done
);

  localparam int PSW  = $clog2(SCAN_DIV);
  localparam int MAXT = DRIVE_TICKS > BLANK_TICKS ? DRIVE_TICKS : BLANK_TICKS;
  localparam int PHW  = $clog2(MAXT + 1);

  logic [PSW-1:0]            prescale;
  logic [PHW-1:0]            phase, phase_nxt;
  logic [1:0]                idx, idx_nxt;
  scan_state_t               state, state_nxt;
  logic [4*NUM_DIGITS-1:0]   pend_value, shadow_value, value_nxt;
  logic [NUM_DIGITS-1:0]     pend_dp, shadow_dp, dp_nxt;
  logic [NUM_DIGITS-1:0]     pend_en, shadow_en, en_nxt;
  logic                      tick, phase_end, boundary, drive_on;
  logic [3:0]                nibble;
  logic [6:0]                seg_raw;

  seg7_hex_decode u_dec (
    .nibble (nibble),
    .seg    (seg_raw)
  );

  assign tick       = prescale == PSW'(SCAN_DIV - 1);
  assign frame_done = boundary;

  // Next-state of the scan FSM; idx names the digit of the upcoming/current DRIVE and steps when a DRIVE ends
  always_comb begin
    phase_end = state == DRIVE ? phase == PHW'(DRIVE_TICKS - 1) : phase == PHW'(BLANK_TICKS - 1);
    boundary  = tick && state == BLANK && phase_end && idx == 2'd0;
    state_nxt = tick && phase_end ? (state == BLANK ? DRIVE : BLANK) : state;
    phase_nxt = tick ? (phase_end ? '0 : phase + PHW'(1)) : phase;
    idx_nxt   = tick && phase_end && state == DRIVE ? idx + 2'd1 : idx;
    value_nxt = boundary ? (load ? value_in : pend_value) : shadow_value;
    dp_nxt    = boundary ? (load ? dp_in : pend_dp) : shadow_dp;
    en_nxt    = boundary ? (load ? en_in : pend_en) : shadow_en;
    nibble    = value_nxt[{idx_nxt, 2'b00} +: 4];
    drive_on  = state_nxt == DRIVE && en_nxt[idx_nxt];
  end

  // Pending registers: last load before a frame boundary wins
  always_ff @(posedge sys_clock) begin
    if (sys_reset) begin
      pend_value <= '0;
      pend_dp    <= '0;
      pend_en    <= '0;
    end else if (load) begin
      pend_value <= value_in;
      pend_dp    <= dp_in;
      pend_en    <= en_in;
    end
  end

  // Prescaler, scan FSM, frame shadow and registered pin drivers (pins follow next-state so they move one cycle after the tick)
  always_ff @(posedge sys_clock) begin
    if (sys_reset) begin
      prescale     <= '0;
      phase        <= '0;
      idx          <= '0;
      state        <= BLANK;
      shadow_value <= '0;
      shadow_dp    <= '0;
      shadow_en    <= '0;
      seg_out      <= {7{ACTIVE_LOW}};
      dp_out       <= ACTIVE_LOW;
      digit_out    <= {NUM_DIGITS{ACTIVE_LOW}};
    end else begin
      prescale     <= tick ? '0 : prescale + PSW'(1);
      phase        <= phase_nxt;
      idx          <= idx_nxt;
      state        <= state_nxt;
      shadow_value <= value_nxt;
      shadow_dp    <= dp_nxt;
      shadow_en    <= en_nxt;
      seg_out      <= {7{ACTIVE_LOW}} ^ (drive_on ? seg_raw : 7'd0);
      dp_out       <= ACTIVE_LOW ^ (drive_on & dp_nxt[idx_nxt]);
      digit_out    <= {NUM_DIGITS{ACTIVE_LOW}} ^ (drive_on ? NUM_DIGITS'(1) << idx_nxt : '0);
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: randomized check of the scan driver against a tick-count reference model
module tb_seg7_scan_driver;

  localparam int SD = 4;
  localparam int DT = 2;
  localparam int BT = 1;
  localparam int P  = DT + BT;
  localparam int FR = 4 * P;

  logic        sys_clock = 1'b0;
  logic        sys_reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  en_in = '0;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  digit_out;
  logic        frame_done;

  seg7_scan_driver #(
    .SCAN_DIV    (SD),
    .DRIVE_TICKS (DT),
    .BLANK_TICKS (BT),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .sys_clock  (sys_clock),
    .sys_reset  (sys_reset),
    .load       (load),
    .value_in   (value_in),
    .dp_in      (dp_in),
    .en_in      (en_in),
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .digit_out  (digit_out),
    .frame_done (frame_done)
  );

  always #5 sys_clock = ~sys_clock;

  logic [6:0] hex_tab [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                               7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                               7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                               7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

  int checks = 0;
  int errors = 0;
  int n = 0;
  logic [15:0] pv = '0, sv = '0;
  logic [3:0]  pd = '0, sdp = '0, pe = '0, se = '0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at n=%0d: got %0h expected %0h", tag, n, got, exp);
    end
  endtask

  function automatic bit is_boundary(int m);
    return m % SD == 0 && m / SD >= BT && (m / SD - BT) % FR == 0;
  endfunction

  function automatic bit in_drive(int m, int k);
    int t = m / SD;
    return t >= BT && ((t - BT) / P) % 4 == k && (t - BT) % P < DT;
  endfunction

  task automatic step(bit r, bit l, logic [15:0] v, logic [3:0] d, logic [3:0] e);
    int t, dig;
    bit on;
    logic [6:0] es;
    logic [3:0] ed;
    logic ep;
    sys_reset = r; load = l; value_in = v; dp_in = d; en_in = e;
    @(posedge sys_clock);
    if (r) begin
      n = 0; pv = '0; pd = '0; pe = '0; sv = '0; sdp = '0; se = '0;
    end else begin
      n++;
      if (is_boundary(n)) {sv, sdp, se} = l ? {v, d, e} : {pv, pd, pe};
      if (l) {pv, pd, pe} = {v, d, e};
    end
    @(negedge sys_clock);
    t = n / SD;
    dig = 0;
    on = 1'b0;
    if (t >= BT) begin
      dig = ((t - BT) / P) % 4;
      on = (t - BT) % P < DT && se[dig];
    end
    es = on ? ~hex_tab[sv[dig*4 +: 4]] : 7'h7f;
    ed = on ? ~(4'b0001 << dig) : 4'hf;
    ep = ~(on & sdp[dig]);
    check("seg_out", 32'(seg_out), 32'(es));
    check("dp_out", 32'(dp_out), 32'(ep));
    check("digit_out", 32'(digit_out), 32'(ed));
    check("frame_done", 32'(frame_done), 32'(is_boundary(n + 1)));
    check("onehot", 32'($countones(~digit_out) <= 1), 32'd1);
  endtask

  task automatic idle(int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, $urandom, $urandom, $urandom);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    step(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
    step(1'b0, 1'b1, 16'h1A8F, 4'b0100, 4'hF);
    idle(60);
    while (!in_drive(n, 1)) idle(1);
    step(1'b0, 1'b1, 16'h0000, 4'h0, 4'hF);
    idle(70);
    for (int i = 0; i < 100 && !is_boundary(n + 1); i++) idle(1);
    step(1'b0, 1'b1, 16'h5555, 4'hA, 4'hF);
    idle(50);
    step(1'b0, 1'b1, 16'h9C3E, 4'hF, 4'b0101);
    idle(110);
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 399) == 0, $urandom_range(0, 15) == 0, 16'($urandom), 4'($urandom), 4'($urandom));
    step(1'b0, 1'b1, 16'h4321, 4'hF, 4'hF);
    for (int i = 0; i < 200 && !in_drive(n, 2); i++) idle(1);
    step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    idle(120);
    step(1'b0, 1'b1, 16'hBEEF, 4'h3, 4'hF);
    idle(100);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Output-side counterpart to the board's debounced switch inputs: drives a 4-digit multiplexed 7-segment display on the test board.
- Takes a 16-bit hex value, decimal points and a digit-enable mask from core logic.
- Time-multiplexes the digits using a prescaled scan tick, with an inter-digit blanking gap that suppresses ghosting.
- Updates the displayed value only at frame boundaries, so a frame never shows a torn value.

Parameters:
- SCAN_DIV, 256: sys_clock cycles per scan tick, ≥2. The prescaler counts 0..SCAN_DIV-1 and ticks on SCAN_DIV-1.
- DRIVE_TICKS, 3: ticks each digit is driven, ≥1.
- BLANK_TICKS, 1: ticks all digits are off between digits, ≥1.
- ACTIVE_LOW, 1: 1 = seg_out, dp_out and digit_out are active-low (common-anode board); 0 = active-high.

Ports:
- sys_clock  in  1  system clock
- sys_reset  in  1  synchronous, active-high reset
- load  in  1  capture value_in, dp_in and en_in this cycle
- value_in  in  16  digit k = value_in[4k+3:4k], digit 0 rightmost
- dp_in  in  4  decimal point per digit
- en_in  in  4  digit enable mask; a disabled digit stays dark in its slot
- seg_out  out  7  segments; bit0 = a … bit6 = g
- dp_out  out  1  decimal point of the active digit
- digit_out  out  4  one-hot digit select
- frame_done  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset is synchronous, active-high, sys_clock only. On reset:
  - prescaler = 0, digit index = 0, state = BLANK, phase counter = 0
  - pending and shadow registers (value, dp, en) = 0
  - all outputs inactive: seg_out, dp_out and digit_out at their inactive level (all ones if ACTIVE_LOW); frame_done = 0
  - Reset mid-scan returns to this state on the next edge, with no partial-digit glitch.
- Load path:
  - load = 1 copies value_in, dp_in and en_in into the pending registers that cycle.
  - A later load before the frame boundary overwrites pending (last write wins).
- Scan FSM advances only on a tick. Its states are DRIVE and BLANK, counted by the phase counter.
  - BLANK: all outputs inactive. After BLANK_TICKS ticks, go to DRIVE and select the next digit index (0→1→2→3→0).
  - DRIVE: the selected digit is driven. After DRIVE_TICKS ticks, go to BLANK.
  - Leaving reset, the first DRIVE is digit 0.
- Frame boundary = the tick that ends the BLANK following digit 3, and the first tick after reset. On the boundary cycle:
  - shadow ← (load ? inputs : pending)
  - frame_done = 1 for exactly that cycle
- Timing:
  - digit period = (DRIVE_TICKS + BLANK_TICKS) × SCAN_DIV cycles; frame = 4 × digit period
  - Outputs are registered: pins change one sys_clock after the tick.
- DRIVE outputs for digit k:
  - digit_out = one-hot bit k
  - seg_out = hex decode of shadow nibble k (0-F)
  - dp_out = shadow dp[k]
  - If shadow en[k] = 0: digit_out, seg_out and dp_out all inactive for the whole slot. Slot timing is unchanged.
  - Polarity is applied last: XOR with ACTIVE_LOW.
- Hex decode, internal active-high (gfedcba):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001
- Invariants:
  - digit_out is never more than one-hot active.
  - Segment changes coincide only with BLANK → DRIVE transitions, never mid-DRIVE.
- Widths:
  - prescaler is $clog2(SCAN_DIV) bits and wraps to 0 after SCAN_DIV-1
  - phase counter sized for max(DRIVE_TICKS, BLANK_TICKS)
  - digit index is 2 bits, natural wrap

Decomposition:
- Shared package holds:
  - the hex-to-segment constant table
  - the scan-state enum (BLANK, DRIVE)
  - NUM_DIGITS = 4
- One sub-module, seg7_hex_decode: combinational nibble → 7-bit active-high pattern. The top instantiates it once, muxed by digit index.

Test Plan (SCAN_DIV=4, DRIVE_TICKS=2, BLANK_TICKS=1; digit period 12 cycles, frame 48):
1. Reset → all outputs 1 (ACTIVE_LOW). After release, frame_done pulses at cycle 3, then 48-cycle period. Outputs stay dark while en = 0.
2. load value_in=16'h1A8F, en_in=4'hF, dp_in=4'b0100 before the first boundary → each 12-cycle slot drives digits in order:
   - digit_out 1110, seg_out ~F (0001110)
   - digit_out 1101, seg_out ~8 (0000000)
   - digit_out 1011, seg_out ~A, dp_out 0
   - digit_out 0111, seg_out ~1 (1111001)
   - each followed by 4 dark cycles
3. Reload value_in=16'h0000 mid-frame (during digit 1) → remaining digits in that frame still show 1A8F. The new value appears only from the next digit-0 slot. Never a mixed frame.
4. load asserted on the exact boundary cycle with 16'h5555 → shadow = 5555 immediately. The next frame shows 5 (1101101, inverted) on all digits.
5. en_in=4'b0101 → digits 1 and 3 fully dark (digit_out bit inactive), slot timing unchanged, frame_done still every 48 cycles.
6. Assert sys_reset during a digit-2 DRIVE → next edge all outputs inactive. Scan restarts at digit 0. Shadow = 0 with en = 0, so the display stays dark until the next load.
